// File: rtl/udcount_pkg.sv
// Shared definitions for the up/down counter job sequencer: register map,
// response codes and sequencer state encoding.
package udcount_pkg;

  // Counter register map
  localparam logic [1:0] ADDR_PLR = 2'd0;
  localparam logic [1:0] ADDR_ULR = 2'd1;
  localparam logic [1:0] ADDR_LLR = 2'd2;
  localparam logic [1:0] ADDR_CCR = 2'd3;

  // Number of counter registers written and read back per job
  localparam int NUM_REGS = 4;

  // Job result codes
  typedef enum logic [1:0] {
    RSP_OK         = 2'd0,
    RSP_RANGE_ERR  = 2'd1,
    RSP_VERIFY_ERR = 2'd2,
    RSP_TIMEOUT    = 2'd3
  } rsp_status_t;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_VERIFY = 3'd2,
    S_CHECK  = 3'd3,
    S_START  = 3'd4,
    S_RUN    = 3'd5,
    S_RESP   = 3'd6
  } seq_state_t;

endpackage

// File: rtl/udcount_seq.sv
// Job-level sequencer for the programmable up/down counter. Accepts a job,
// writes and reads back the four counter registers, checks the range flag,
// starts the counter, waits for end-of-count (bounded by a timeout) and
// returns a status plus elapsed RUN cycles. All outputs come from flops.
module udcount_seq
  import udcount_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CYW            = 16
) (
  input  logic           clk,
  input  logic           rst,
  // job request
  input  logic           job_valid,
  output logic           job_ready,
  input  logic [7:0]     job_plr,
  input  logic [7:0]     job_ulr,
  input  logic [7:0]     job_llr,
  input  logic [7:0]     job_ccr,
  // job response
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [1:0]     rsp_status,
  output logic [CYW-1:0] rsp_cycles,
  output logic           busy,
  // counter register bus (strobes active-low)
  output logic [1:0]     cnt_a,
  output logic           cnt_ncs,
  output logic           cnt_nwr,
  output logic           cnt_nrd,
  output logic [7:0]     cnt_din,
  input  logic [7:0]     cnt_dout,
  input  logic           cnt_err,
  input  logic           cnt_ec,
  output logic           cnt_start
);

  localparam logic [CYW-1:0] TIMEOUT_VAL = CYW'(TIMEOUT_CYCLES);

  // Sequencer state
  seq_state_t        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              mismatch_q, mismatch_d;
  logic [CYW-1:0]    cyc_q, cyc_d;
  logic [CYW-1:0]    cyc_inc;
  rsp_status_t       status_q, status_d;
  logic [CYW-1:0]    rsp_cycles_q, rsp_cycles_d;

  // Latched job fields, indexed by register address
  logic [NUM_REGS-1:0][7:0] job_field;
  logic [NUM_REGS-1:0][7:0] field_q, field_d;
  logic                     accept;

  // Registered outputs
  logic        ncs_q, ncs_d;
  logic        nwr_q, nwr_d;
  logic        nrd_q, nrd_d;
  logic [1:0]  a_q, a_d;
  logic [7:0]  din_q, din_d;
  logic        start_q, start_d;
  logic        job_ready_q, job_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        busy_q, busy_d;

  assign job_field[ADDR_PLR] = job_plr;
  assign job_field[ADDR_ULR] = job_ulr;
  assign job_field[ADDR_LLR] = job_llr;
  assign job_field[ADDR_CCR] = job_ccr;

  // A job is taken only while idle; job_ready mirrors the IDLE state
  assign accept = (state_q == S_IDLE) && job_valid;

  // Field capture: load all four on acceptance, otherwise hold
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_field
    assign field_d[gi] = accept ? job_field[gi] : field_q[gi];
  end

  // Next-state logic plus decode of the registered outputs from the next state
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mismatch_d   = mismatch_q;
    cyc_d        = cyc_q;
    status_d     = status_q;
    rsp_cycles_d = rsp_cycles_q;
    cyc_inc      = cyc_q + CYW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_WRITE;
          idx_d      = 2'd0;
          mismatch_d = 1'b0;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = S_VERIFY;
          idx_d   = 2'd0;
        end
      end
      S_VERIFY: begin
        // read data is combinational from the counter, compare in-cycle
        if (cnt_dout != field_q[idx_q]) begin
          mismatch_d = 1'b1;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = S_CHECK;
          idx_d   = 2'd0;
        end
      end
      S_CHECK: begin
        // a readback mismatch outranks the counter's own range flag
        if (mismatch_q) begin
          state_d      = S_RESP;
          status_d     = RSP_VERIFY_ERR;
          rsp_cycles_d = '0;
        end else if (cnt_err) begin
          state_d      = S_RESP;
          status_d     = RSP_RANGE_ERR;
          rsp_cycles_d = '0;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        cyc_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        // end-of-count wins over a timeout landing on the same cycle
        if (cnt_ec) begin
          state_d      = S_RESP;
          status_d     = RSP_OK;
          rsp_cycles_d = cyc_inc;
        end else if (cyc_inc == TIMEOUT_VAL) begin
          state_d      = S_RESP;
          status_d     = RSP_TIMEOUT;
          rsp_cycles_d = cyc_inc;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output decode from the upcoming state so every strobe is a flop
    ncs_d       = !((state_d == S_WRITE) || (state_d == S_VERIFY));
    nwr_d       = (state_d != S_WRITE);
    nrd_d       = (state_d != S_VERIFY);
    a_d         = ((state_d == S_WRITE) || (state_d == S_VERIFY)) ? idx_d : 2'd0;
    din_d       = (state_d == S_WRITE) ? field_d[idx_d] : 8'h00;
    start_d     = (state_d == S_START);
    job_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      mismatch_q   <= 1'b0;
      cyc_q        <= '0;
      status_q     <= RSP_OK;
      rsp_cycles_q <= '0;
      field_q      <= '0;
      ncs_q        <= 1'b1;
      nwr_q        <= 1'b1;
      nrd_q        <= 1'b1;
      a_q          <= 2'd0;
      din_q        <= 8'h00;
      start_q      <= 1'b0;
      job_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mismatch_q   <= mismatch_d;
      cyc_q        <= cyc_d;
      status_q     <= status_d;
      rsp_cycles_q <= rsp_cycles_d;
      field_q      <= field_d;
      ncs_q        <= ncs_d;
      nwr_q        <= nwr_d;
      nrd_q        <= nrd_d;
      a_q          <= a_d;
      din_q        <= din_d;
      start_q      <= start_d;
      job_ready_q  <= job_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign job_ready  = job_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = status_q;
  assign rsp_cycles = rsp_cycles_q;
  assign busy       = busy_q;
  assign cnt_a      = a_q;
  assign cnt_ncs    = ncs_q;
  assign cnt_nwr    = nwr_q;
  assign cnt_nrd    = nrd_q;
  assign cnt_din    = din_q;
  assign cnt_start  = start_q;

endmodule
